flag_cond_unit: RTL and testbench

- Architectural NZCV status register and condition-code evaluator. It sits on the far side of the ADD/ALU flag interface.
- Captures `New_Flag` from the ALU when a flag-setting op (S=1) retires, and drives the registered flags back to the ALU `Flag` input.
- Evaluates 4-bit branch/predication condition codes against the registered flags.
- Includes a small save/restore stack for exception entry and return.

---
 rtl/flag_pkg.sv | 33 +++
 rtl/cond_eval.sv | 43 ++++
 rtl/flag_cond_unit.sv | 119 +++++++++++
 tb/tb_flag_cond_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | flag_pkg : NZCV bit indices, condition codes and flag type         |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package flag_pkg;

   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   typedef logic [3:0] flags_t;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cond_eval : combinational 4-bit condition code check vs NZCV       |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module cond_eval
   import flag_pkg::*;
(
   input  logic [3:0] cond,
   input  flags_t     flags,
   output logic       pass
);

   logic n, z, c, v;

   always_comb begin
      n    = flags[FLG_N];
      z    = flags[FLG_Z];
      c    = flags[FLG_C];
      v    = flags[FLG_V];
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/flag_cond_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | flag_cond_unit : NZCV status register, condition evaluator, and    |
// |                  flag save/restore stack. Macro: FLAG_BYPASS_EN    |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module flag_cond_unit
   import flag_pkg::*;
#(
   parameter int STACK_DEPTH = 4,
   parameter int SP_W        = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       flag_we,
   input  flags_t     new_flag,
   output flags_t     flag_out,
   input  logic       cond_valid,
   input  logic [3:0] cond,
   output logic       cond_pass_valid,
   output logic       cond_pass,
   input  logic       push,
   input  logic       pop,
   output logic       stack_full,
   output logic       stack_empty,
   output logic       stack_err
);

   localparam int              IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

   flags_t          flag_q, flag_d;
   logic [SP_W-1:0] sp_q, sp_d, sp_m1;
   logic            err_q, err_d;
   logic            valid_q, valid_d;
   logic            pass_q, pass_d;
   flags_t          stack_q [STACK_DEPTH];

   logic   full, empty, push_ok, pop_ok;
   flags_t stack_top, eval_flags;
   logic   eval_pass;

   assign full      = (sp_q == SP_FULL);
   assign empty     = (sp_q == '0);
   assign sp_m1     = sp_q - SP_ONE;
   assign stack_top = stack_q[sp_m1[IDX_W-1:0]];

   // Simultaneous push and pop cancel each other without raising an error.
   assign push_ok = push & ~pop & ~full;
   assign pop_ok  = pop & ~push & ~empty;

`ifdef FLAG_BYPASS_EN
   assign eval_flags = flag_we ? new_flag : flag_q;
`else
   assign eval_flags = flag_q;
`endif

   cond_eval u_cond_eval (
      .cond  (cond),
      .flags (eval_flags),
      .pass  (eval_pass)
   );

   always_comb begin
      flag_d  = flag_q;
      sp_d    = sp_q;
      err_d   = err_q;
      valid_d = cond_valid;
      pass_d  = eval_pass;

      if (push_ok) begin
         sp_d = sp_q + SP_ONE;
      end else if (pop_ok) begin
         sp_d   = sp_m1;
         flag_d = stack_top;
      end

      if ((push & ~pop & full) | (pop & ~push & empty)) begin
         err_d = 1'b1;
      end

      // An ALU flag write wins over a restore; the popped entry is still consumed.
      if (flag_we) begin
         flag_d = new_flag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flag_q  <= '0;
         sp_q    <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         flag_q  <= flag_d;
         sp_q    <= sp_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         pass_q  <= pass_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         stack_q[sp_q[IDX_W-1:0]] <= flag_q;
      end
   end

   assign flag_out        = flag_q;
   assign cond_pass_valid = valid_q;
   assign cond_pass       = pass_q;
   assign stack_full      = full;
   assign stack_empty     = empty;
   assign stack_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_flag_cond_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_flag_cond_unit : scoreboard bench for flag_cond_unit            |
// | Revision          : 1.0                                            |
// +--------------------------------------------------------------------+
module tb_flag_cond_unit;

`ifdef FLAG_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flag_we = 1'b0;
   logic [3:0] new_flag = 4'h0;
   logic [3:0] flag_out;
   logic       cond_valid = 1'b0;
   logic [3:0] cond = 4'h0;
   logic       cond_pass_valid;
   logic       cond_pass;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic       stack_full;
   logic       stack_empty;
   logic       stack_err;

   flag_cond_unit #(.STACK_DEPTH(DEPTH), .SP_W(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .flag_we         (flag_we),
      .new_flag        (new_flag),
      .flag_out        (flag_out),
      .cond_valid      (cond_valid),
      .cond            (cond),
      .cond_pass_valid (cond_pass_valid),
      .cond_pass       (cond_pass),
      .push            (push),
      .pop             (pop),
      .stack_full      (stack_full),
      .stack_empty     (stack_empty),
      .stack_err       (stack_err)
   );

   always #5 clk = ~clk;

   int         vectors = 0;
   int         miscompares = 0;
   bit         exp_q[$];
   logic [3:0] m_flags = 4'h0;
   logic [3:0] m_stack [DEPTH];
   int         m_sp = 0;
   bit         m_err = 1'b0;

   // Reference condition table, written from the architectural definitions.
   function automatic bit ref_eval(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cy;
         4'h3: return !cy;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cy && !z;
         4'h9: return !cy || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // One clock of stimulus; updates the reference model and scoreboard.
   task automatic drive(input bit we, input logic [3:0] nf, input bit cv,
                        input logic [3:0] cc, input bit pu, input bit po);
      logic [3:0] nxt;
      flag_we = we; new_flag = nf; cond_valid = cv; cond = cc; push = pu; pop = po;
      if (cv && !rst) exp_q.push_back(ref_eval(cc, (BYP && we) ? nf : m_flags));
      nxt = m_flags;
      if (rst) begin
         nxt = 4'h0; m_sp = 0; m_err = 1'b0;
      end else begin
         if (pu && !po) begin
            if (m_sp == DEPTH) m_err = 1'b1;
            else begin m_stack[m_sp] = m_flags; m_sp++; end
         end else if (po && !pu) begin
            if (m_sp == 0) m_err = 1'b1;
            else begin m_sp--; nxt = m_stack[m_sp]; end
         end
         if (we) nxt = nf;
      end
      m_flags = nxt;
      @(posedge clk);
      #1;
      flag_we = 1'b0; cond_valid = 1'b0; push = 1'b0; pop = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 4'h0, 0, 4'h0, 0, 0);
      drive(0, 4'h0, 0, 4'h0, 0, 0);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(1, 4'hF, 0, 4'h0, 1, 0);
      // Query launched in the same cycle as reset must produce no strobe.
      rst = 1'b1;
      drive(0, 4'h0, 1, 4'hE, 0, 0);
      drive(0, 4'h0, 0, 4'h0, 0, 0);
      rst = 1'b0;
      exp_q.delete();
      vectors++;
      if (flag_out !== 4'h0 || cond_pass_valid !== 1'b0 || cond_pass !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got flags=%b valid=%b pass=%b, want 0000 0 0",
                  flag_out, cond_pass_valid, cond_pass);
      end
      vectors++;
      if (stack_empty !== 1'b1 || stack_full !== 1'b0 || stack_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_stack: got empty=%b full=%b err=%b, want 1 0 0",
                  stack_empty, stack_full, stack_err);
      end
      drive(0, 4'h0, 0, 4'h0, 0, 0);
      vectors++;
      if (cond_pass_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_no_strobe: got valid=%b, want 0", cond_pass_valid);
      end
   endtask

   task automatic test_cond_basic();
      logic [3:0] codes [2] = '{4'hE, 4'h0};
      bit         want  [2] = '{1'b1, 1'b0};
      bit         e;
      for (int i = 0; i < 2; i++) begin
         drive(0, 4'h0, 1, codes[i], 0, 0);
         e = exp_q.pop_front();
         vectors++;
         if (cond_pass_valid !== 1'b1 || cond_pass !== e || e !== want[i]) begin
            miscompares++;
            $display("FAIL basic_cond%0h: got valid=%b pass=%b, want 1 %b",
                     codes[i], cond_pass_valid, cond_pass, want[i]);
         end
      end
      vectors++;
      if (flag_out !== 4'b0000) begin
         miscompares++;
         $display("FAIL basic_flags: got %b, want 0000", flag_out);
      end
   endtask

   task automatic test_flag_capture();
      logic [3:0] codes [5] = '{4'h4, 4'hA, 4'h0, 4'h8, 4'h9};
      bit         want  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      bit         e;
      for (int i = 0; i < 5; i++) begin
         if (i == 0) begin
            drive(1, 4'b1000, 0, 4'h0, 0, 0);
            vectors++;
            if (flag_out !== 4'b1000) begin
               miscompares++;
               $display("FAIL capture_1000: got %b, want 1000", flag_out);
            end
         end
         if (i == 2) begin
            drive(1, 4'b0110, 0, 4'h0, 0, 0);
            vectors++;
            if (flag_out !== 4'b0110) begin
               miscompares++;
               $display("FAIL capture_0110: got %b, want 0110", flag_out);
            end
         end
         drive(0, 4'h0, 1, codes[i], 0, 0);
         e = exp_q.pop_front();
         vectors++;
         if (cond_pass_valid !== 1'b1 || cond_pass !== e || e !== want[i]) begin
            miscompares++;
            $display("FAIL capture_cond%0h: got valid=%b pass=%b, want 1 %b",
                     codes[i], cond_pass_valid, cond_pass, want[i]);
         end
      end
   endtask

   task automatic test_bypass();
      bit e;
      drive(1, 4'b0000, 0, 4'h0, 0, 0);
      drive(1, 4'b0100, 1, 4'h0, 0, 0);
      e = exp_q.pop_front();
      vectors++;
      if (cond_pass_valid !== 1'b1 || cond_pass !== e || e !== BYP) begin
         miscompares++;
         $display("FAIL bypass_eq: got valid=%b pass=%b, want 1 %b",
                  cond_pass_valid, cond_pass, BYP);
      end
      vectors++;
      if (flag_out !== 4'b0100) begin
         miscompares++;
         $display("FAIL bypass_flags: got %b, want 0100", flag_out);
      end
   endtask

   task automatic test_stack();
      logic [3:0] vals [4] = '{4'b0001, 4'b1010, 4'b0110, 4'b1101};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, vals[i], 0, 4'h0, 0, 0);
         drive(0, 4'h0, 0, 4'h0, 1, 0);
      end
      vectors++;
      if (stack_full !== 1'b1 || stack_empty !== 1'b0 || stack_err !== 1'b0) begin
         miscompares++;
         $display("FAIL stack_full4: got full=%b empty=%b err=%b, want 1 0 0",
                  stack_full, stack_empty, stack_err);
      end
      drive(1, 4'b1111, 0, 4'h0, 0, 0);
      drive(0, 4'h0, 0, 4'h0, 1, 0);
      vectors++;
      if (stack_err !== 1'b1 || stack_full !== 1'b1) begin
         miscompares++;
         $display("FAIL stack_overflow: got err=%b full=%b, want 1 1", stack_err, stack_full);
      end
      for (int i = 3; i >= 0; i--) begin
         drive(0, 4'h0, 0, 4'h0, 0, 1);
         vectors++;
         if (flag_out !== vals[i] || flag_out !== m_flags) begin
            miscompares++;
            $display("FAIL stack_pop%0d: got %b, want %b", i, flag_out, vals[i]);
         end
      end
      drive(0, 4'h0, 0, 4'h0, 0, 1);
      vectors++;
      if (flag_out !== vals[0] || stack_empty !== 1'b1 || stack_err !== 1'b1) begin
         miscompares++;
         $display("FAIL stack_underflow: got flags=%b empty=%b err=%b, want %b 1 1",
                  flag_out, stack_empty, stack_err, vals[0]);
      end
   endtask

   task automatic test_pop_we();
      do_reset();
      drive(1, 4'b0010, 0, 4'h0, 0, 0);
      drive(0, 4'h0, 0, 4'h0, 1, 0);
      drive(1, 4'b1001, 0, 4'h0, 0, 1);
      vectors++;
      if (flag_out !== 4'b1001 || stack_empty !== 1'b1 || stack_err !== 1'b0) begin
         miscompares++;
         $display("FAIL pop_we: got flags=%b empty=%b err=%b, want 1001 1 0",
                  flag_out, stack_empty, stack_err);
      end
   endtask

   task automatic test_push_pop();
      do_reset();
      drive(1, 4'b0101, 0, 4'h0, 0, 0);
      drive(0, 4'h0, 0, 4'h0, 1, 0);
      drive(1, 4'b1110, 0, 4'h0, 0, 0);
      drive(0, 4'h0, 0, 4'h0, 1, 1);
      vectors++;
      if (flag_out !== 4'b1110 || stack_empty !== 1'b0 || stack_err !== 1'b0) begin
         miscompares++;
         $display("FAIL push_pop_same: got flags=%b empty=%b err=%b, want 1110 0 0",
                  flag_out, stack_empty, stack_err);
      end
      drive(0, 4'h0, 0, 4'h0, 0, 1);
      vectors++;
      if (flag_out !== 4'b0101 || stack_empty !== 1'b1) begin
         miscompares++;
         $display("FAIL push_pop_after: got flags=%b empty=%b, want 0101 1",
                  flag_out, stack_empty);
      end
   endtask

   task automatic test_back_to_back();
      bit         e;
      logic [3:0] nf, cc;
      bit         we, pu, po;
      do_reset();
      for (int i = 0; i < 80; i++) begin
         we = ($urandom_range(0, 1) == 1);
         nf = 4'($urandom_range(0, 15));
         cc = 4'($urandom_range(0, 15));
         pu = ($urandom_range(0, 3) == 0);
         po = ($urandom_range(0, 3) == 0);
         drive(we, nf, 1, cc, pu, po);
         e = exp_q.pop_front();
         vectors++;
         if (cond_pass_valid !== 1'b1 || cond_pass !== e) begin
            miscompares++;
            $display("FAIL b2b_cond%0d: cond=%h got valid=%b pass=%b, want 1 %b",
                     i, cc, cond_pass_valid, cond_pass, e);
         end
         vectors++;
         if (flag_out !== m_flags || stack_empty !== (m_sp == 0) ||
             stack_full !== (m_sp == DEPTH) || stack_err !== m_err) begin
            miscompares++;
            $display("FAIL b2b_state%0d: got flags=%b e=%b f=%b err=%b, want %b %b %b %b",
                     i, flag_out, stack_empty, stack_full, stack_err,
                     m_flags, (m_sp == 0), (m_sp == DEPTH), m_err);
         end
      end
   endtask

   initial begin
      do_reset();
      test_reset();
      test_cond_basic();
      test_flag_capture();
      test_bypass();
      test_stack();
      test_pop_we();
      test_push_pop();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
